if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, runs a request/acknowledge transaction on the instruction-memory port for each instruction, and holds the fetched word until the pipeline advances. It feeds `if_pc`/`if_inst` into the IF/ID pipeline register and raises a stall request to the stall controller while no instruction is available. Branch redirects arriving from ID, including ones raised during a fetch stall, are recorded and applied after the delay slot.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 6: stall-controller vector; only `stall[0]` is used (1 = PC hold).
- `branch_flag` in 1: ID requests a redirect after the delay slot.
- `branch_target` in 32: redirect address; bits [1:0] are ignored.
- `mem_req` out 1: fetch request.
- `mem_addr` out 32: fetch address, `{pc[31:2],2'b00}`.
- `mem_ack` in 1: one-cycle completion strobe, valid only while `mem_req`=1.
- `mem_rdata` in 32: instruction word, valid in the `mem_ack` cycle.
- `if_pc` out 32: PC of the presented instruction, to the IF/ID register.
- `if_inst` out 32: presented instruction; 0 (NOP) when none is held.
- `stall_req` out 1: 1 while no instruction is held.

## Operation
- Registers: `pc`, `inst_buf`, `state`, `pend`, `pend_target`.
- State machine:
  - IDLE: reset state. Goes to REQ on the next cycle unconditionally.
  - REQ: `mem_req`=1. On `mem_ack`, latch `mem_rdata` into `inst_buf` and go to READY. Otherwise stay in REQ with the address stable.
  - READY: `mem_req`=0. When `stall[0]`=0, advance the PC and go to REQ. Otherwise stay in READY.
- Output mapping:
  - `stall_req` = (state != READY).
  - `if_inst` = `inst_buf` in READY, otherwise 0.
  - `if_pc` = `pc` at all times.
- Advance edge (state READY and `stall[0]`=0): next PC is chosen in priority order:
  1. `branch_flag` → `branch_target`
  2. else `pend` → `pend_target`
  3. else `pc`+4 (modulo 2^32, wraps 0xFFFF_FFFC → 0)
  
  `pend` clears on every advance.
- Deferred branch: if `branch_flag`=1 on an edge where no advance occurs (any state), set `pend`=1 and `pend_target`=`branch_target`. A repeated assertion overwrites `pend_target`.
- The presented instruction is always the delay slot and is always consumed; no fetched word is discarded.
- `mem_ack` outside REQ is a protocol violation and is ignored. The bench asserts on it.
- `stall[0]` in REQ or IDLE has no effect; the stall controller holds the pipeline there via `stall_req`.

## Timing
- Reset values: `pc`=`RESET_PC`, state=IDLE, `pend`=0, `pend_target`=0, `inst_buf`=0. This gives `mem_req`=0, `if_inst`=0, `stall_req`=1, `if_pc`=`RESET_PC`.
- Reset asserted mid-transaction abandons the request. The memory slave shares `rst`.
- After `rst` deasserts:
  - cycle 0: IDLE
  - cycle 1: first `mem_req`
- Ack may arrive in the first REQ cycle. READY begins the cycle after ack.
- Throughput: at best, REQ+ack → READY → advance, i.e. 2 cycles per instruction. Each extra ack-wait cycle adds 1.
- `mem_addr` is stable throughout REQ.
- `branch_flag` and an advance on the same edge: the redirect applies immediately and is not recorded in `pend`.

## Structure
- Shared package `cpu_pkg`:
  - stall-bit index constants (`STALL_PC`=0 … 5)
  - `NOP`=32'h0
  - fetch state encoding (IDLE/REQ/READY)
  - default reset PC
- Single module with no sub-modules; the FSM and next-PC mux are small enough to stay flat.

## Test plan
- Reset release, `mem_ack` tied 1, stall=0 → addresses 0, 4, 8 issued on cycles 1, 3, 5. `if_inst` matches the memory words in cycles 2, 4, 6. `stall_req` low only in those cycles.
- Ack delayed 3 cycles after req → `mem_req` high 3 cycles with `mem_addr` constant. `stall_req` stays 1 until the cycle after ack.
- `branch_flag`=1, target 0x100, in a READY cycle with stall=0 → next `mem_addr`=0x100.
- `branch_flag`=1, target 0x200, while in REQ, then flag deasserts → delay-slot word presented at pc, next fetch is 0x200, `pend` clears.
- READY with `stall[0]`=1 for 4 cycles → `if_pc`/`if_inst` held, no `mem_req`. Advance occurs on the first edge where `stall[0]`=0.
- `RESET_PC`=0xFFFF_FFFC → second fetch address 0x0000_0000. `rst` pulsed during REQ → IDLE next cycle and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: stall vector bit positions, the NOP encoding,
// the fetch FSM state encoding and the default reset PC.
package cpu_pkg;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_READY = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge port between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per request/ack
// transaction and presents it to IF/ID until the pipeline advances.
//
// state       | meaning
// ------------+-------------------------------------------------
// FETCH_IDLE  | just out of reset, no request yet
// FETCH_REQ   | mem_req high, waiting for mem_ack
// FETCH_READY | word held in inst_buf, waiting for stall[0]=0
module if_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    if_fetch_if.master  mem,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stall_req
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  inst_buf;
    logic         pend;
    logic [31:0]  pend_target;
    logic         advance;
    logic [31:0]  target_aligned;

    // Only the PC-hold bit and the word-aligned part of the target matter here.
    logic unused_bits;
    assign unused_bits = ^{stall[5:1], branch_target[1:0]};

    assign target_aligned = {branch_target[31:2], 2'b00};
    assign advance        = (state == FETCH_READY) && !stall[STALL_PC];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE:  state_nxt = FETCH_REQ;
            FETCH_REQ:   if (mem.mem_ack) state_nxt = FETCH_READY;
            FETCH_READY: if (!stall[STALL_PC]) state_nxt = FETCH_REQ;
            default:     state_nxt = FETCH_IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req = (state == FETCH_REQ);
        stall_req   = (state != FETCH_READY);
        if_inst     = (state == FETCH_READY) ? inst_buf : NOP;
    end

    assign mem.mem_addr = {pc[31:2], 2'b00};
    assign if_pc        = pc;

    // A redirect seen on the advance edge wins over one recorded earlier.
    always_comb begin
        if (branch_flag) begin
            pc_nxt = target_aligned;
        end else if (pend) begin
            pc_nxt = pend_target;
        end else begin
            pc_nxt = pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC_ALIGNED;
            inst_buf    <= NOP;
            pend        <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            if (advance) begin
                pc   <= pc_nxt;
                pend <= 1'b0;
            end else if (branch_flag) begin
                pend        <= 1'b1;
                pend_target <= target_aligned;
            end
            if ((state == FETCH_REQ) && mem.mem_ack) begin
                inst_buf <= mem.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: cycle table from reset, hand sequences
// for ack wait, deferred branch, reset mid-request and PC wrap.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] if_pc, if_inst, w_pc, w_inst;
    logic        stall_req, w_sreq;
    int          ack_delay = 0;
    int          wcnt = 0;
    int          total = 0;
    int          bad = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] present_q[$];

    if_fetch_if m0();
    if_fetch_if m1();

    if_fetch u_dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .mem(m0.master),
        .if_pc(if_pc), .if_inst(if_inst), .stall_req(stall_req)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst_w), .stall(6'd0), .branch_flag(1'b0),
        .branch_target(32'h0), .mem(m1.master),
        .if_pc(w_pc), .if_inst(w_inst), .stall_req(w_sreq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    // Memory for the main DUT: ack after ack_delay extra wait cycles.
    always @(negedge clk) begin
        m0.mem_rdata = word_at(m0.mem_addr);
        if (!rst && m0.mem_req) begin
            m0.mem_ack = (wcnt == ack_delay);
            wcnt = m0.mem_ack ? 0 : wcnt + 1;
        end else begin
            m0.mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    assign m1.mem_ack   = m1.mem_req;
    assign m1.mem_rdata = word_at(m1.mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic sreq, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".mem_req"}, {31'd0, m0.mem_req}, {31'd0, req});
        if (req) chk({tag, ".mem_addr"}, m0.mem_addr, addr);
        chk({tag, ".stall_req"}, {31'd0, stall_req}, {31'd0, sreq});
        chk({tag, ".if_pc"}, if_pc, pc);
        chk({tag, ".if_inst"}, if_inst, inst);
    endtask

    // Scoreboard: fetch completions and instruction consumption on the main DUT.
    always @(posedge clk) begin
        if (!rst && m0.mem_req && m0.mem_ack) begin
            if (exp_addr_q.size() == 0) begin
                chk("sb_unexpected_fetch", m0.mem_addr, 32'hDEAD_DEAD);
            end else begin
                logic [31:0] a;
                a = exp_addr_q.pop_front();
                chk("sb_fetch_addr", m0.mem_addr, a);
                present_q.push_back(a);
            end
        end
        if (!rst && !stall_req && !stall[0]) begin
            if (present_q.size() == 0) begin
                chk("sb_unexpected_consume", if_pc, 32'hDEAD_DEAD);
            end else begin
                logic [31:0] p;
                p = present_q.pop_front();
                chk("sb_consume_pc", if_pc, p);
                chk("sb_consume_inst", if_inst, word_at(p));
            end
        end
    end

    always @(posedge clk) begin
        if (m0.mem_ack && !m0.mem_req) begin
            bad++;
            $display("FAIL ack_outside_req actual=ack=1,req=0 required=req=1 at %0t", $time);
        end
    end

    typedef struct {
        logic        stall0;
        logic        br;
        logic [31:0] tgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_sreq;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t tbl[14];

    task automatic do_reset(input int delay);
        rst = 1'b1;
        stall = 6'd0;
        branch_flag = 1'b0;
        tick();
        tick();
        ack_delay = delay;
        rst = 1'b0;
    endtask

    initial begin
        //       stall br  tgt           req addr          sreq pc            inst
        tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0,   32'h0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b1, 32'h0,   32'h0};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   word_at(32'h0)};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h4,   32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4,   word_at(32'h4)};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h8,   32'h0};
        tbl[6]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h8,   word_at(32'h8)};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 32'h100, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, word_at(32'h100)};
        tbl[9]  = '{1'b1, 1'b1, 32'h403, 1'b0, 32'h0,   1'b0, 32'h100, word_at(32'h100)};
        tbl[10] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, word_at(32'h100)};
        tbl[11] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, word_at(32'h100)};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, word_at(32'h100)};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h400, 1'b1, 32'h400, 32'h0};

        // Reset values while rst is held.
        tick();
        chk_out("reset", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);

        // Table: ack in first REQ cycle, branch in READY, stalled READY with deferred branch.
        do_reset(0);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h8);
        exp_addr_q.push_back(32'h100);
        for (int k = 0; k < 14; k++) begin
            chk_out($sformatf("tbl%0d", k), tbl[k].exp_req, tbl[k].exp_addr,
                    tbl[k].exp_sreq, tbl[k].exp_pc, tbl[k].exp_inst);
            stall[0]      = tbl[k].stall0;
            branch_flag   = tbl[k].br;
            branch_target = tbl[k].tgt;
            if (k != 13) tick();
        end

        // Ack after two wait cycles, branch raised twice during REQ.
        do_reset(2);
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h0);
        chk_out("wait.c0", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk_out($sformatf("wait.c%0d", c), 1'b1, 32'h0, 1'b1, 32'h0, 32'h0);
        end
        tick();
        chk_out("wait.ready", 1'b0, 32'h0, 1'b0, 32'h0, word_at(32'h0));
        tick();
        chk_out("pend.req0", 1'b1, 32'h4, 1'b1, 32'h4, 32'h0);
        branch_flag = 1'b1;
        branch_target = 32'h300;
        tick();
        chk_out("pend.req1", 1'b1, 32'h4, 1'b1, 32'h4, 32'h0);
        branch_target = 32'h200;
        tick();
        branch_flag = 1'b0;
        chk_out("pend.req2", 1'b1, 32'h4, 1'b1, 32'h4, 32'h0);
        tick();
        chk_out("pend.slot", 1'b0, 32'h0, 1'b0, 32'h4, word_at(32'h4));
        tick();
        chk_out("pend.tgt", 1'b1, 32'h200, 1'b1, 32'h200, 32'h0);
        tick();
        tick();
        tick();
        chk_out("pend.tgt_ready", 1'b0, 32'h0, 1'b0, 32'h200, word_at(32'h200));
        tick();
        chk_out("pend.cleared", 1'b1, 32'h204, 1'b1, 32'h204, 32'h0);

        // Reset pulse in REQ abandons the request and restarts at RESET_PC.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("rstpulse.idle", 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
        tick();
        chk_out("rstpulse.req", 1'b1, 32'h0, 1'b1, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        chk_out("rstpulse.ready", 1'b0, 32'h0, 1'b0, 32'h0, word_at(32'h0));
        tick();
        rst = 1'b1;
        tick();

        chk("sb_addr_q_empty", exp_addr_q.size(), 32'd0);
        chk("sb_present_q_empty", present_q.size(), 32'd0);

        // PC wrap from RESET_PC = 0xFFFF_FFFC.
        rst_w = 1'b0;
        chk("wrap.c0.pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap.c0.req", {31'd0, m1.mem_req}, 32'd0);
        tick();
        chk("wrap.c1.req", {31'd0, m1.mem_req}, 32'd1);
        chk("wrap.c1.addr", m1.mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap.c2.sreq", {31'd0, w_sreq}, 32'd0);
        chk("wrap.c2.inst", w_inst, word_at(32'hFFFF_FFFC));
        tick();
        chk("wrap.c3.req", {31'd0, m1.mem_req}, 32'd1);
        chk("wrap.c3.addr", m1.mem_addr, 32'h0);
        chk("wrap.c3.pc", w_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
